// File: rtl/sdram_dev_resp_if.sv
// SDR SDRAM command/data bus: the controller drives the master side, the device responder sits on the slave side.
interface sdram_dev_resp_if #(
   parameter int DW = 32
);
   logic            scke;
   logic            scs_n;
   logic            sras_n;
   logic            scas_n;
   logic            swe_n;
   logic [10:0]     saddr;
   logic [1:0]      sba;
   logic [DW/8-1:0] sdqm;
   logic [DW-1:0]   sdata_i;
   logic [DW-1:0]   sdata_o;
   logic            sdata_oe;
   logic [10:0]     mode_reg;
   logic            err;
   logic [2:0]      err_code;
   logic [15:0]     ref_cnt;

   modport master (output scke, scs_n, sras_n, scas_n, swe_n, saddr, sba, sdqm, sdata_i,
                   input  sdata_o, sdata_oe, mode_reg, err, err_code, ref_cnt);
   modport slave  (input  scke, scs_n, sras_n, scas_n, swe_n, saddr, sba, sdqm, sdata_i,
                   output sdata_o, sdata_oe, mode_reg, err, err_code, ref_cnt);
endinterface

// File: rtl/sdram_dev_resp.sv
// SDR SDRAM device responder with internal RAM; SDRAM_DEV_TIMING_CHK_EN adds tRCD/tRP checking.
// Latency: write data captured on the command edge; first read beat sampled by the controller CL edges after READ.
// Backpressure: none; scke=0 freezes every register including the burst and read pipeline.
module sdram_dev_resp #(
   parameter int ROW_W = 4,
   parameter int COL_W = 8,
   parameter int DW    = 32,
   parameter int T_RCD = 3,
   parameter int T_RP  = 3
) (
   input  logic            sclk,
   input  logic            srst_n,
   sdram_dev_resp_if.slave bus
);
   localparam int BE    = DW / 8;
   localparam int AW    = 2 + ROW_W + COL_W;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} bst_t;

   bst_t             r_st, w_st_nx;
   logic [DW-1:0]    r_mem [DEPTH];
   logic [3:0]       r_open;
   logic [ROW_W-1:0] r_row [4];
   logic             r_mode_vld, r_cl3, r_mfull;
   logic [COL_W-1:0] r_mmask;
   logic [1:0]       r_bbank;
   logic [ROW_W-1:0] r_brow;
   logic [COL_W-1:0] r_bbase, r_bn, r_bmask;
   logic             r_bfull, r_bap;
   logic             r_fv, r_f2v, r_dqm1, r_oe;
   logic [DW-1:0]    r_fd, r_f2d, r_do;
   logic [10:0]      r_mode;
   logic             r_err;
   logic [2:0]       r_ecode;
   logic [15:0]      r_ref;

   logic             w_cs, w_act, w_rd, w_wr, w_pre, w_ref, w_lmr, w_bst;
   logic             w_bank_open, w_new, w_stop, w_bl_ok, w_cl_ok, w_lmr_full;
   logic [COL_W-1:0] w_lmr_mask;
   logic             w_beat, w_beat_wr, w_last, w_ap, w_full, w_ap_close;
   logic [1:0]       w_bank;
   logic [ROW_W-1:0] w_row;
   logic [COL_W-1:0] w_base, w_n, w_mask, w_col;
   logic [AW-1:0]    w_addr;
   logic             w_src_v, w_trcd_bad, w_trp_bad;
   logic [DW-1:0]    w_src_d;
   logic [2:0]       w_err_code;

   assign w_cs  = bus.scke & ~bus.scs_n;
   assign w_act = w_cs & ({bus.sras_n, bus.scas_n, bus.swe_n} == 3'b011);
   assign w_rd  = w_cs & ({bus.sras_n, bus.scas_n, bus.swe_n} == 3'b101);
   assign w_wr  = w_cs & ({bus.sras_n, bus.scas_n, bus.swe_n} == 3'b100);
   assign w_pre = w_cs & ({bus.sras_n, bus.scas_n, bus.swe_n} == 3'b010);
   assign w_ref = w_cs & ({bus.sras_n, bus.scas_n, bus.swe_n} == 3'b001);
   assign w_lmr = w_cs & ({bus.sras_n, bus.scas_n, bus.swe_n} == 3'b000);
   assign w_bst = w_cs & ({bus.sras_n, bus.scas_n, bus.swe_n} == 3'b110);

   assign w_bank_open = r_open[bus.sba];
   assign w_new       = (w_rd | w_wr) & w_bank_open;
   assign w_stop      = w_bst | (w_pre & (bus.saddr[10] | (bus.sba == r_bbank)));
   assign w_cl_ok     = (bus.saddr[6:4] == 3'd2) || (bus.saddr[6:4] == 3'd3);

   always_comb begin
      w_lmr_mask = '0;
      w_lmr_full = 1'b0;
      w_bl_ok    = 1'b1;
      case (bus.saddr[2:0])
         3'b000:  w_lmr_mask = COL_W'(0);
         3'b001:  w_lmr_mask = COL_W'(1);
         3'b010:  w_lmr_mask = COL_W'(3);
         3'b011:  w_lmr_mask = COL_W'(7);
         3'b111:  begin w_lmr_mask = '1; w_lmr_full = 1'b1; end
         default: w_bl_ok = 1'b0;
      endcase
   end

   // A new READ/WRITE owns the edge; otherwise an unstopped burst continues.
   always_comb begin
      w_st_nx   = r_st;
      w_beat    = 1'b0;
      w_beat_wr = 1'b0;
      w_bank    = r_bbank;
      w_row     = r_brow;
      w_base    = r_bbase;
      w_n       = r_bn;
      w_mask    = r_bmask;
      w_full    = r_bfull;
      w_ap      = r_bap;
      if (w_new) begin
         w_beat    = 1'b1;
         w_beat_wr = w_wr;
         w_bank    = bus.sba;
         w_row     = r_row[bus.sba];
         w_base    = bus.saddr[COL_W-1:0];
         w_n       = '0;
         w_mask    = r_mmask;
         w_full    = r_mfull;
         w_ap      = bus.saddr[10] & ~r_mfull;
      end else if (bus.scke && r_st != S_IDLE && !w_stop) begin
         w_beat    = 1'b1;
         w_beat_wr = (r_st == S_WR);
      end
      w_last = w_beat & ~w_full & (w_n == w_mask);
      if (w_beat)
         w_st_nx = w_last ? S_IDLE : (w_beat_wr ? S_WR : S_RD);
      else if (w_stop)
         w_st_nx = S_IDLE;
   end

   assign w_col      = (w_base & ~w_mask) | ((w_base + w_n) & w_mask);
   assign w_addr     = {w_bank, w_row, w_col};
   assign w_ap_close = w_last & w_ap;
   assign w_src_v    = r_cl3 ? r_f2v : r_fv;
   assign w_src_d    = r_cl3 ? r_f2d : r_fd;

`ifdef SDRAM_DEV_TIMING_CHK_EN
   localparam logic [7:0] RCD8 = 8'(T_RCD);
   localparam logic [7:0] RP8  = 8'(T_RP);
   logic [7:0] r_tcnt [4];

   // Counter holds cycles since the bank's last ACTIVE/PRECHARGE, saturating.
   always_ff @(posedge sclk) begin
      if (!srst_n) begin
         for (int b = 0; b < 4; b++) r_tcnt[b] <= '1;
      end else if (bus.scke) begin
         for (int b = 0; b < 4; b++) begin
            if (((w_act || w_pre) && bus.sba == 2'(b)) || (w_pre && bus.saddr[10]) ||
                (w_ap_close && w_bank == 2'(b)))
               r_tcnt[b] <= 8'd1;
            else if (r_tcnt[b] != 8'hFF)
               r_tcnt[b] <= r_tcnt[b] + 8'd1;
         end
      end
   end
   assign w_trcd_bad = r_tcnt[bus.sba] < RCD8;
   assign w_trp_bad  = r_tcnt[bus.sba] < RP8;
`else
   assign w_trcd_bad = 1'b0 && (T_RCD != 0);
   assign w_trp_bad  = 1'b0 && (T_RP != 0);
`endif

   always_comb begin
      w_err_code = 3'd0;
      if ((w_rd | w_wr) & ~w_bank_open)                 w_err_code = 3'd1;
      else if (w_act & w_bank_open)                     w_err_code = 3'd2;
      else if ((w_ref | w_lmr) & (|r_open))             w_err_code = 3'd3;
      else if ((w_act | w_rd | w_wr) & ~r_mode_vld)     w_err_code = 3'd4;
      else if (w_lmr & ~(w_bl_ok & w_cl_ok))            w_err_code = 3'd5;
      else if ((w_rd | w_wr) & w_trcd_bad)              w_err_code = 3'd6;
      else if (w_act & w_trp_bad)                       w_err_code = 3'd7;
   end

   always_ff @(posedge sclk) begin
      if (!srst_n) begin
         r_st <= S_IDLE;  r_open <= '0;  r_mode_vld <= 1'b0;
         r_cl3 <= 1'b1;   r_mmask <= '0; r_mfull <= 1'b0;
         r_bbank <= '0;   r_brow <= '0;  r_bbase <= '0; r_bn <= '0;
         r_bmask <= '0;   r_bfull <= 1'b0; r_bap <= 1'b0;
         r_fv <= 1'b0;    r_f2v <= 1'b0; r_f2d <= '0; r_dqm1 <= 1'b0;
         r_oe <= 1'b0;    r_do <= '0;    r_mode <= '0;
         r_err <= 1'b0;   r_ecode <= '0; r_ref <= '0;
      end else if (bus.scke) begin
         r_st <= w_st_nx;
         if (w_beat) begin
            r_bbank <= w_bank; r_brow <= w_row;   r_bbase <= w_base; r_bn <= w_n + 1'b1;
            r_bmask <= w_mask; r_bfull <= w_full; r_bap <= w_ap;
         end
         // An accepted WRITE takes the data bus, discarding any read beats in flight.
         if (w_new && w_wr) begin
            r_fv <= 1'b0; r_f2v <= 1'b0; r_oe <= 1'b0; r_do <= '0;
         end else begin
            r_fv  <= w_beat & ~w_beat_wr;
            r_f2v <= r_fv;
            r_f2d <= r_fd;
            r_oe  <= w_src_v & ~r_dqm1;
            r_do  <= w_src_v ? w_src_d : '0;
         end
         r_dqm1 <= |bus.sdqm;
         if (w_ap_close) r_open[w_bank] <= 1'b0;
         if (w_act) begin
            r_open[bus.sba] <= 1'b1;
            r_row[bus.sba]  <= bus.saddr[ROW_W-1:0];
         end
         if (w_pre) begin
            if (bus.saddr[10]) r_open <= '0;
            else               r_open[bus.sba] <= 1'b0;
         end
         if (w_lmr) begin
            r_mode     <= bus.saddr;
            r_mode_vld <= 1'b1;
            r_cl3      <= !(w_bl_ok && w_cl_ok) || (bus.saddr[6:4] == 3'd3);
            r_mmask    <= (w_bl_ok && w_cl_ok) ? w_lmr_mask : '0;
            r_mfull    <= w_bl_ok && w_cl_ok && w_lmr_full;
         end
         if (w_ref && r_ref != 16'hFFFF) r_ref <= r_ref + 16'd1;
         if (!r_err && w_err_code != 3'd0) begin
            r_err   <= 1'b1;
            r_ecode <= w_err_code;
         end
      end
   end

   always_ff @(posedge sclk) begin
      if (srst_n && w_beat && w_beat_wr) begin
         for (int i = 0; i < BE; i++)
            if (!bus.sdqm[i]) r_mem[w_addr][8*i +: 8] <= bus.sdata_i[8*i +: 8];
      end
      if (srst_n && w_beat && !w_beat_wr) r_fd <= r_mem[w_addr];
   end

   assign bus.sdata_o  = r_do;
   assign bus.sdata_oe = r_oe;
   assign bus.mode_reg = r_mode;
   assign bus.err      = r_err;
   assign bus.err_code = r_ecode;
   assign bus.ref_cnt  = r_ref;
endmodule

// File: tb/tb_sdram_dev_resp.sv
// Directed bench for sdram_dev_resp: reset, CL/BL wrap, DQM, full page + terminate, errors, refresh, clock suspend.
module tb_sdram_dev_resp;
   logic sclk = 1'b0;
   logic srst_n;
   int   n_chk = 0;
   int   n_pass = 0;

   localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR  = 3'b100;
   localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000, C_BST = 3'b110;

   sdram_dev_resp_if bus ();
   sdram_dev_resp dut (.sclk(sclk), .srst_n(srst_n), .bus(bus));

   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic issue(input logic [2:0] c, input logic [1:0] ba = 2'd0, input logic [10:0] a = 11'd0,
                        input logic [31:0] d = 32'd0, input logic [3:0] m = 4'd0);
      bus.scs_n = 1'b0;
      {bus.sras_n, bus.scas_n, bus.swe_n} = c;
      bus.sba = ba; bus.saddr = a; bus.sdata_i = d; bus.sdqm = m;
      @(posedge sclk); #1;
   endtask

   task automatic nop(input int n);
      repeat (n) issue(C_NOP);
   endtask

   // Observed after edge e: the beat the controller samples at edge e+1.
   task automatic beat(input string tag, input logic v, input logic [31:0] d);
      check({tag, ".oe"}, 32'(bus.sdata_oe), 32'(v));
      if (v) check({tag, ".dat"}, bus.sdata_o, d);
   endtask

   task automatic do_reset;
      srst_n = 1'b0;
      bus.scke = 1'b1;
      nop(2);
      srst_n = 1'b1;
   endtask

   function automatic logic [31:0] bpat(input int i);
      return 32'h0101_0101 * (32'hB0 + 32'(i));
   endfunction

   initial begin
      bus.scke = 1'b1; bus.scs_n = 1'b1; bus.sras_n = 1'b1; bus.scas_n = 1'b1; bus.swe_n = 1'b1;
      bus.saddr = '0; bus.sba = '0; bus.sdqm = '0; bus.sdata_i = '0;
      do_reset;
      check("rst_oe",   32'(bus.sdata_oe), 32'd0);
      check("rst_dat",  bus.sdata_o,       32'd0);
      check("rst_mode", 32'(bus.mode_reg), 32'd0);
      check("rst_err",  32'(bus.err),      32'd0);
      check("rst_code", 32'(bus.err_code), 32'd0);
      check("rst_ref",  32'(bus.ref_cnt),  32'd0);

      // CL3 BL4: write at col C, read from col E wraps inside the 4-block.
      issue(C_LMR, 0, 11'h032);
      check("t1_mode", 32'(bus.mode_reg), 32'h032);
      issue(C_ACT, 1, 11'd5); nop(2);
      for (int i = 0; i < 4; i++) issue(i == 0 ? C_WR : C_NOP, 1, 11'h00C, 32'hA000_00A0 + 32'(i));
      issue(C_PRE, 1, 11'd0); nop(2);
      issue(C_ACT, 1, 11'd5); nop(2);
      issue(C_RD, 1, 11'h00E);
      issue(C_NOP); beat("t1_lat", 1'b0, 32'd0);
      issue(C_NOP); beat("t1_b0", 1'b1, 32'hA000_00A2);
      issue(C_NOP); beat("t1_b1", 1'b1, 32'hA000_00A3);
      issue(C_NOP); beat("t1_b2", 1'b1, 32'hA000_00A0);
      issue(C_NOP); beat("t1_b3", 1'b1, 32'hA000_00A1);
      issue(C_NOP); beat("t1_end", 1'b0, 32'd0);
      check("t1_err", 32'(bus.err), 32'd0);

      // CL2 BL8 with read DQM, then partial-lane write and write-flush of a read.
      issue(C_PRE, 0, 11'h400); nop(2);
      issue(C_LMR, 0, 11'h023);
      issue(C_ACT, 0, 11'd3); nop(2);
      for (int i = 0; i < 8; i++) issue(i == 0 ? C_WR : C_NOP, 0, 11'h010, bpat(i));
      issue(C_RD, 0, 11'h013);
      issue(C_NOP, 0, 11'd0, 32'd0, 4'hF); beat("t2_b0", 1'b1, bpat(3));
      issue(C_NOP, 0, 11'd0, 32'd0, 4'hF); beat("t2_b1", 1'b0, 32'd0);
      issue(C_NOP); beat("t2_b2", 1'b0, 32'd0);
      for (int n = 3; n < 8; n++) begin
         issue(C_NOP); beat($sformatf("t2_b%0d", n), 1'b1, bpat((3 + n) % 8));
      end
      issue(C_NOP); beat("t2_end", 1'b0, 32'd0);
      issue(C_WR, 0, 11'h010, 32'h1122_3344, 4'b0101);
      issue(C_BST);
      issue(C_RD, 0, 11'h010);
      issue(C_NOP); beat("t2_dqmwr", 1'b1, 32'h11B0_33B0);
      issue(C_WR, 0, 11'h018, 32'hCAFE_F00D); beat("t2_flush", 1'b0, 32'd0);
      issue(C_BST); beat("t2_flush2", 1'b0, 32'd0);
      check("t2_err", 32'(bus.err), 32'd0);

      // Full page from col FE, terminated on the fifth edge.
      issue(C_PRE, 0, 11'h400); nop(2);
      issue(C_LMR, 0, 11'h037);
      issue(C_ACT, 2, 11'd1); nop(2);
      for (int i = 0; i < 4; i++) issue(i == 0 ? C_WR : C_NOP, 2, 11'h0FE, 32'hC000_00C0 + 32'(i));
      issue(C_BST);
      issue(C_RD, 2, 11'h0FE);
      issue(C_NOP); beat("t3_lat", 1'b0, 32'd0);
      issue(C_NOP); beat("t3_fe", 1'b1, 32'hC000_00C0);
      issue(C_NOP); beat("t3_ff", 1'b1, 32'hC000_00C1);
      issue(C_BST); beat("t3_00", 1'b1, 32'hC000_00C2);
      issue(C_NOP); beat("t3_01", 1'b1, 32'hC000_00C3);
      issue(C_NOP); beat("t3_end", 1'b0, 32'd0);
      issue(C_NOP); beat("t3_end2", 1'b0, 32'd0);
      check("t3_err", 32'(bus.err), 32'd0);

      // READ to idle bank is dropped and sets code 1; a later error keeps it.
      do_reset;
      issue(C_LMR, 0, 11'h032);
      issue(C_RD, 0, 11'd0);
      check("t4_err", 32'(bus.err), 32'd1);
      check("t4_code", 32'(bus.err_code), 32'd1);
      for (int i = 0; i < 4; i++) begin
         issue(C_NOP); beat($sformatf("t4_nooe%0d", i), 1'b0, 32'd0);
      end
      issue(C_ACT, 3, 11'd0); nop(2);
      issue(C_ACT, 3, 11'd0);
      check("t4_err2", 32'(bus.err), 32'd1);
      check("t4_code2", 32'(bus.err_code), 32'd1);

      issue(C_PRE, 0, 11'h400);
      repeat (3) issue(C_REF);
      check("t5_ref3", 32'(bus.ref_cnt), 32'd3);

      // Refresh with a bank open, then a read stretched by two suspended cycles.
      do_reset;
      issue(C_LMR, 0, 11'h032);
      issue(C_ACT, 2, 11'd0); nop(2);
      issue(C_REF);
      check("t5_code", 32'(bus.err_code), 32'd3);
      check("t5_ref1", 32'(bus.ref_cnt), 32'd1);
      for (int i = 0; i < 4; i++) issue(i == 0 ? C_WR : C_NOP, 2, 11'h020, 32'hD000_00D0 + 32'(i));
      issue(C_RD, 2, 11'h020);
      issue(C_NOP); beat("t5_lat", 1'b0, 32'd0);
      bus.scke = 1'b0;
      issue(C_NOP); beat("t5_hold0", 1'b0, 32'd0);
      issue(C_NOP); beat("t5_hold1", 1'b0, 32'd0);
      bus.scke = 1'b1;
      for (int n = 0; n < 4; n++) begin
         issue(C_NOP); beat($sformatf("t5_b%0d", n), 1'b1, 32'hD000_00D0 + 32'(n));
      end
      issue(C_NOP); beat("t5_end", 1'b0, 32'd0);

      // READ one cycle after ACTIVE.
      do_reset;
      issue(C_LMR, 0, 11'h032);
      issue(C_ACT, 0, 11'd0);
      issue(C_RD, 0, 11'd0);
`ifdef SDRAM_DEV_TIMING_CHK_EN
      check("t6_err", 32'(bus.err), 32'd1);
      check("t6_code", 32'(bus.err_code), 32'd6);
`else
      check("t6_err", 32'(bus.err), 32'd0);
      check("t6_code", 32'(bus.err_code), 32'd0);
`endif
      nop(6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
